dis7seg_scan: RTL and testbench

Parametrised, time-multiplexed 7-segment display driver for the toy-dog status panel. It drives DIGITS common-segment digits from one shared segment bus, with hex decoding, a per-digit decimal point, blanking and blinking. Digit refresh runs from a clock prescaler with an anti-ghosting blank slot. It sits between the speed/state logic, which loads the values to show, and the board's display pins.

---
 rtl/dis7seg_scan.sv | 155 +++++++++++++++
 tb/tb_dis7seg_scan.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dis7seg_scan.sv
// Time-multiplexed 7-segment driver: shadow registers, slot prescaler with one
// dark cycle either side of each digit change, hex decode, blanking and blinking.
module dis7seg_scan #(
    parameter int DIGITS     = 4,
    parameter int CLK_DIV    = 50000,
    parameter int BLINK_DIV  = 64,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic [DIGITS-1:0]     blink_in,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an
);

    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int NSLOT  = 1 << IDX_W;
    localparam int PCNT_W = $clog2(CLK_DIV);
    localparam int BCNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(CLK_DIV - 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLINK_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

    typedef enum logic {
        ST_SHOW  = 1'b0,
        ST_BLANK = 1'b1
    } slot_state_t;

    slot_state_t         state;
    logic [PCNT_W-1:0]   pcnt;
    logic [IDX_W-1:0]    idx;
    logic [BCNT_W-1:0]   bcnt;
    logic                blink_phase;

    logic [4*DIGITS-1:0] data_r;
    logic [DIGITS-1:0]   dp_r;
    logic [DIGITS-1:0]   blank_r;
    logic [DIGITS-1:0]   blink_r;

    logic [3:0]          data_slot [NSLOT];
    logic [NSLOT-1:0]    dp_slot;
    logic [NSLOT-1:0]    blank_slot;
    logic [NSLOT-1:0]    blink_slot;
    logic [DIGITS-1:0]   an_onehot;

    logic                tick;
    logic                lit;
    logic [6:0]          cur_seg;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Pad per-digit views out to a power of two so idx always selects a valid entry;
    // unused slots read as blanked and are never reached anyway.
    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
        if (gi < DIGITS) begin : g_real
            assign data_slot[gi]  = data_r[4*gi +: 4];
            assign dp_slot[gi]    = dp_r[gi];
            assign blank_slot[gi] = blank_r[gi];
            assign blink_slot[gi] = blink_r[gi];
        end else begin : g_pad
            assign data_slot[gi]  = 4'h0;
            assign dp_slot[gi]    = 1'b0;
            assign blank_slot[gi] = 1'b1;
            assign blink_slot[gi] = 1'b0;
        end
    end

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_onehot
        assign an_onehot[gi] = (idx == IDX_W'(gi));
    end

    assign tick    = (pcnt == PCNT_LAST);
    assign cur_seg = hex7(data_slot[idx]);
    assign lit     = !tick && (state == ST_SHOW) && !blank_slot[idx]
                     && !(blink_slot[idx] && blink_phase);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_BLANK;
            pcnt        <= '0;
            idx         <= '0;
            bcnt        <= '0;
            blink_phase <= 1'b0;
            data_r      <= '0;
            dp_r        <= '0;
            blank_r     <= '1;
            blink_r     <= '0;
            seg         <= {7{ACTIVE_LOW}};
            dp          <= ACTIVE_LOW;
            an          <= {DIGITS{ACTIVE_LOW}};
        end else begin
            if (load) begin
                data_r  <= data_in;
                dp_r    <= dp_in;
                blank_r <= blank_in;
                blink_r <= blink_in;
            end

            if (tick) begin
                pcnt  <= '0;
                state <= ST_BLANK;
                idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                if (bcnt == BCNT_LAST) begin
                    bcnt        <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    bcnt <= bcnt + 1'b1;
                end
            end else begin
                pcnt  <= pcnt + 1'b1;
                state <= ST_SHOW;
            end

            // Output decision uses the pre-edge index, so the tick edge and the
            // following BLANK edge both leave the bus dark around the digit change.
            if (lit) begin
                an  <= an_onehot ^ {DIGITS{ACTIVE_LOW}};
                seg <= cur_seg ^ {7{ACTIVE_LOW}};
                dp  <= dp_slot[idx] ^ ACTIVE_LOW;
            end else begin
                an  <= {DIGITS{ACTIVE_LOW}};
                seg <= {7{ACTIVE_LOW}};
                dp  <= ACTIVE_LOW;
            end
        end
    end

endmodule

// File: tb/tb_dis7seg_scan.sv
// Bench for dis7seg_scan: three instances (active-low 4-digit, active-high 4-digit,
// single digit) checked every cycle against a time-indexed expectation queue.
module tb_dis7seg_scan;

    localparam int CDIV = 4;
    localparam logic [6:0] HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef struct {
        int          n;
        logic [15:0] m;
        logic [15:0] h;
        logic [15:0] s;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;

    logic [15:0] m_data, h_data;
    logic [3:0]  m_dp, m_blank, m_blink, h_dp, h_blank, h_blink;
    logic [3:0]  s_data;
    logic [0:0]  s_dp, s_blank, s_blink;

    logic [6:0]  m_seg, h_seg, s_seg;
    logic        m_dpo, h_dpo, s_dpo;
    logic [3:0]  m_an, h_an;
    logic [0:0]  s_an;

    // Bench-side copy of what each instance should have captured.
    logic [15:0] sh_m_data, sh_h_data;
    logic [3:0]  sh_m_dp, sh_m_blank, sh_m_blink, sh_h_dp, sh_h_blank, sh_h_blink;
    logic [3:0]  sh_s_data;
    logic [0:0]  sh_s_dp, sh_s_blank, sh_s_blink;

    exp_t q[$];
    int   n;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    dis7seg_scan #(.DIGITS(4), .CLK_DIV(CDIV), .BLINK_DIV(8), .ACTIVE_LOW(1'b1)) u_main (
        .clk(clk), .rst_n(rst_n), .load(load), .data_in(m_data), .dp_in(m_dp),
        .blank_in(m_blank), .blink_in(m_blink), .seg(m_seg), .dp(m_dpo), .an(m_an)
    );

    dis7seg_scan #(.DIGITS(4), .CLK_DIV(CDIV), .BLINK_DIV(2), .ACTIVE_LOW(1'b0)) u_hex (
        .clk(clk), .rst_n(rst_n), .load(load), .data_in(h_data), .dp_in(h_dp),
        .blank_in(h_blank), .blink_in(h_blink), .seg(h_seg), .dp(h_dpo), .an(h_an)
    );

    dis7seg_scan #(.DIGITS(1), .CLK_DIV(CDIV), .BLINK_DIV(1), .ACTIVE_LOW(1'b1)) u_one (
        .clk(clk), .rst_n(rst_n), .load(load), .data_in(s_data), .dp_in(s_dp),
        .blank_in(s_blank), .blink_in(s_blink), .seg(s_seg), .dp(s_dpo), .an(s_an)
    );

    // Expected {an, seg, dp} after edge n (n=1 is the first edge after reset release),
    // derived from elapsed slots rather than from any counter state.
    function automatic logic [15:0] model(input int d, input int b, input bit al, input int nn,
                                          input logic [31:0] data, input logic [7:0] dpv,
                                          input logic [7:0] blk, input logic [7:0] bln);
        int         p, slot, ix;
        logic [7:0] an_m, mask;
        logic [6:0] seg_m;
        logic       dp_m;
        an_m  = '0;
        seg_m = '0;
        dp_m  = 1'b0;
        if (nn > 0) begin
            p    = (nn - 1) % CDIV;
            slot = (nn - 1) / CDIV;
            ix   = slot % d;
            if (p != 0 && p != CDIV - 1 && !blk[ix] && !(bln[ix] && ((slot / b) % 2 == 1))) begin
                an_m  = 8'(1) << ix;
                seg_m = HEX[data[4*ix +: 4]];
                dp_m  = dpv[ix];
            end
        end
        if (al) begin
            mask  = (8'(1) << d) - 8'd1;
            an_m  = ~an_m & mask;
            seg_m = ~seg_m;
            dp_m  = ~dp_m;
        end
        return {an_m, seg_m, dp_m};
    endfunction

    task automatic chk(input string name, input int nn, input logic [15:0] act, input logic [15:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s edge=%0d got=%h want=%h", name, nn, act, want);
        end else begin
            $display("ok   %s edge=%0d out=%h", name, nn, act);
        end
    endtask

    task automatic reset_model();
        sh_m_data = '0; sh_m_dp = '0; sh_m_blank = '1; sh_m_blink = '0;
        sh_h_data = '0; sh_h_dp = '0; sh_h_blank = '1; sh_h_blink = '0;
        sh_s_data = '0; sh_s_dp = '0; sh_s_blank = '1; sh_s_blink = '0;
        n = 0;
    endtask

    // One clock: drive inputs at the falling edge and queue what the next rising edge must produce.
    task automatic step(input bit ld, input bit rel);
        exp_t e;
        @(negedge clk);
        if (rel) begin
            rst_n = 1'b1;
            n     = 1;
        end
        e.n = n;
        e.m = model(4, 8, 1'b1, n, {16'h0, sh_m_data}, {4'h0, sh_m_dp}, {4'hF, sh_m_blank}, {4'h0, sh_m_blink});
        e.h = model(4, 2, 1'b0, n, {16'h0, sh_h_data}, {4'h0, sh_h_dp}, {4'hF, sh_h_blank}, {4'h0, sh_h_blink});
        e.s = model(1, 1, 1'b1, n, {28'h0, sh_s_data}, {7'h0, sh_s_dp}, {7'h7F, sh_s_blank}, {7'h0, sh_s_blink});
        q.push_back(e);
        load = ld;
        if (ld) begin
            sh_m_data = m_data; sh_m_dp = m_dp; sh_m_blank = m_blank; sh_m_blink = m_blink;
            sh_h_data = h_data; sh_h_dp = h_dp; sh_h_blank = h_blank; sh_h_blink = h_blink;
            sh_s_data = s_data; sh_s_dp = s_dp; sh_s_blank = s_blank; sh_s_blink = s_blink;
        end
        if (n > 0) n++;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0);
    endtask

    task automatic chk_dark(input string tag);
        chk({tag, "_main"}, n, {4'h0, m_an, m_seg, m_dpo}, {4'h0, 4'hF, 7'h7F, 1'b1});
        chk({tag, "_hex"},  n, {4'h0, h_an, h_seg, h_dpo}, {4'h0, 4'h0, 7'h00, 1'b0});
        chk({tag, "_one"},  n, {7'h0, s_an, s_seg, s_dpo}, {7'h0, 1'b1, 7'h7F, 1'b1});
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("main", e.n, {4'h0, m_an, m_seg, m_dpo}, e.m);
                chk("hex",  e.n, {4'h0, h_an, h_seg, h_dpo}, e.h);
                chk("one",  e.n, {7'h0, s_an, s_seg, s_dpo}, e.s);
            end
        end
    end

    initial begin : driver
        rst_n = 1'b1;
        load  = 1'b0;
        m_data = '0; m_dp = '0; m_blank = '0; m_blink = '0;
        h_data = '0; h_dp = '0; h_blank = '0; h_blink = '0;
        s_data = '0; s_dp = '0; s_blank = '0; s_blink = '0;
        reset_model();

        #2 rst_n = 1'b0;
        #1 chk_dark("rst_async");
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        run(47);                                  // three frames dark without a load

        // Scan: digits 0..3 show 0,1,2,3 with dp on digit 2 only.
        m_data = 16'h3210; m_dp = 4'b0100; m_blank = '0; m_blink = '0;
        h_data = 16'h3210; h_dp = 4'b1000;
        s_data = 4'h5;     s_dp = 1'b1;     s_blank = 1'b0;
        step(1'b1, 1'b0);
        run(31);

        // Hex sweep on the active-high instance; main starts blinking digit 0.
        m_blink = 4'b0001;
        for (int v = 0; v < 16; v++) begin
            h_data = {4'(15 - v), 4'(v ^ 5), 4'(v + 3), 4'(v)};
            h_dp   = 4'(v);
            s_data = 4'(v);
            s_blink = (v >= 8) ? 1'b1 : 1'b0;
            step(1'b1, 1'b0);
            run(15);
        end

        // Load coinciding with a tick edge: the next digit must use the new data.
        while (n % CDIV != 0) step(1'b0, 1'b0);
        m_data = 16'hABCD; m_blink = '0; m_dp = 4'b0001;
        step(1'b1, 1'b0);
        run(16);

        // Load mid-slot while a digit is lit.
        while ((n - 1) % CDIV != 1) step(1'b0, 1'b0);
        m_data = 16'h9E8F;
        step(1'b1, 1'b0);
        run(16);

        // Everything blanked.
        m_blank = 4'hF; h_blank = 4'hF; s_blank = 1'b1;
        step(1'b1, 1'b0);
        run(32);

        // Unblank, then pull reset while a digit is lit.
        m_blank = '0; h_blank = '0; s_blank = 1'b0; s_blink = 1'b0;
        step(1'b1, 1'b0);
        while ((n - 1) % CDIV != 1) step(1'b0, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        reset_model();
        #1 chk_dark("rst_mid");
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        run(47);

        @(posedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
